sha_core_arbiter: RTL and testbench
===================================

Name: sha_core_arbiter

Overview:
Shares one SHA-512/HMAC core (512-bit AXI4SR data in, one digest beat out per packet) between N_REQ requester streams. Packet-granular round-robin arbitration: a requester holds the core from its first beat through tlast. Each granted packet's requester index is queued so the core's digest beats are returned to the requester that issued the packet. It sits between the per-flow input FIFOs and the single hash core in the verify path.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 512, tdata width; tkeep width is DATA_W/8
ID_W, 6, tid width
TAG_DEPTH, 8, power of 2 >= 2; max packets issued to the core whose digest has not yet been returned

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s_req_tvalid  in  N_REQ  per-requester beat valid
s_req_tready  out  N_REQ  per-requester ready
s_req_tdata  in  N_REQ*DATA_W  requester data, requester i at slice i
s_req_tkeep  in  N_REQ*DATA_W/8  requester keep
s_req_tid  in  N_REQ*ID_W  requester id
s_req_tlast  in  N_REQ  end of packet
m_core_tvalid/tready/tdata/tkeep/tid/tlast  out/in/out/out/out/out  1/1/DATA_W/DATA_W/8/ID_W/1  stream to hash core
s_core_tvalid  in  1  digest valid from core
s_core_tready  out  1  digest ready to core
s_core_tdata  in  DATA_W  digest
m_res_tvalid  out  N_REQ  digest valid for requester i
m_res_tready  in  N_REQ  requester i accepts digest
m_res_tdata  out  DATA_W  digest, broadcast to all requesters

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, rr_ptr=0, tag FIFO empty, all tready/tvalid outputs 0. A packet in flight is abandoned; upstream and core must be reset in the same cycle.
- FSM IDLE: each cycle, when the tag FIFO is not full, search s_req_tvalid starting at rr_ptr, wrapping modulo N_REQ. On the first hit, register grant=i and go to PASS. No hit, or tag FIFO full: stay in IDLE. All s_req_tready=0 and m_core_tvalid=0 in IDLE.
- FSM PASS: combinational mux of requester `grant`:
  - m_core_* = s_req_*[grant];
  - s_req_tready[grant] = m_core_tready; all other s_req_tready = 0.
- On tlast handshake in PASS:
  - push grant into tag FIFO;
  - rr_ptr <= (grant+1) mod N_REQ;
  - go to IDLE.
- Latency: first beat is available on m_core one cycle after the request becomes visible in IDLE. There is a one-cycle bubble between consecutive packets.
- Fairness: a requester whose tvalid is held high is served within N_REQ-1 packets.
- Data is never reordered or modified within a packet; tid passes through unchanged.
- Result return:
  - Tag FIFO empty: s_core_tready=0 and all m_res_tvalid=0.
  - Otherwise, with head=h: m_res_tvalid[h]=s_core_tvalid, s_core_tready=m_res_tready[h], all other m_res_tvalid=0.
  - Pop on the s_core handshake.
  - m_res_tdata = s_core_tdata.
- Tag FIFO overflow is impossible: a grant requires not-full, and only one push can occur between a grant and its tlast.
- Tag FIFO push and pop in the same cycle: occupancy unchanged. Head and tail pointers wrap modulo TAG_DEPTH.
- Single-beat packet (tlast on the first beat): one beat in PASS, then push.
- A requester dropping tvalid mid-packet keeps the grant; there is no timeout.
- tready to the granted requester never depends on any other requester's valid.

Optional Feature:
SHA_ARB_STATS_EN:
- Adds output stat_pkts (N_REQ*32): a per-requester packet count, incremented on the tlast handshake of that requester, wrapping at 2^32.
- Adds output stat_mismatch_q (1): set when a digest arrives while the tag FIFO is empty (protocol error), cleared only by reset.
- The counters reset to 0.
- Without the macro, these ports and this logic do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset, then requester 2 sends a 3-beat packet (tdata=0x11,0x22,0x33, tid=5) with the core always ready -> m_core shows the same 3 beats and tid 5 starting 1 cycle after valid; tag FIFO holds {2}. The core then returns digest 0xAB -> m_res_tvalid=4'b0100, data 0xAB, and the FIFO becomes empty.
2. All 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0,1 with one idle cycle between packets.
3. Core digests stalled and TAG_DEPTH=8 -> exactly 8 packets granted, then all s_req_tready=0. Returning one digest allows exactly one more grant.
4. Digest for the head tag while m_res_tready[head]=0 for 5 cycles -> s_core_tready=0 for those cycles and digest data held stable; the pop happens on the cycle ready rises.
5. Reset asserted on beat 2 of a 4-beat packet -> the next cycle has state IDLE, all readies 0, FIFO empty, and rr_ptr=0.
6. With SHA_ARB_STATS_EN: 3 packets from requester 1 and 1 from requester 3 -> stat_pkts[1]=3 and stat_pkts[3]=1. Injecting a digest with the FIFO empty sets stat_mismatch_q=1.

Source files
------------

// File: rtl/sha_core_arbiter_if.sv
// Stream bundle between requester FIFOs, the shared hash core and the arbiter.
// The arbiter connects through the slave modport; the master side drives requesters and core.
interface sha_core_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 512,
    parameter int ID_W   = 6
);
    logic [N_REQ-1:0]          s_req_tvalid;
    logic [N_REQ-1:0]          s_req_tready;
    logic [N_REQ*DATA_W-1:0]   s_req_tdata;
    logic [N_REQ*DATA_W/8-1:0] s_req_tkeep;
    logic [N_REQ*ID_W-1:0]     s_req_tid;
    logic [N_REQ-1:0]          s_req_tlast;

    logic                      m_core_tvalid;
    logic                      m_core_tready;
    logic [DATA_W-1:0]         m_core_tdata;
    logic [DATA_W/8-1:0]       m_core_tkeep;
    logic [ID_W-1:0]           m_core_tid;
    logic                      m_core_tlast;

    logic                      s_core_tvalid;
    logic                      s_core_tready;
    logic [DATA_W-1:0]         s_core_tdata;

    logic [N_REQ-1:0]          m_res_tvalid;
    logic [N_REQ-1:0]          m_res_tready;
    logic [DATA_W-1:0]         m_res_tdata;

    modport slave (
        input  s_req_tvalid, s_req_tdata, s_req_tkeep, s_req_tid, s_req_tlast,
        output s_req_tready,
        output m_core_tvalid, m_core_tdata, m_core_tkeep, m_core_tid, m_core_tlast,
        input  m_core_tready,
        input  s_core_tvalid, s_core_tdata,
        output s_core_tready,
        output m_res_tvalid, m_res_tdata,
        input  m_res_tready
    );

    modport master (
        output s_req_tvalid, s_req_tdata, s_req_tkeep, s_req_tid, s_req_tlast,
        input  s_req_tready,
        input  m_core_tvalid, m_core_tdata, m_core_tkeep, m_core_tid, m_core_tlast,
        output m_core_tready,
        output s_core_tvalid, s_core_tdata,
        input  s_core_tready,
        input  m_res_tvalid, m_res_tdata,
        output m_res_tready
    );
endinterface

// File: rtl/sha_core_arbiter.sv
// Purpose: packet-granular round-robin share of one SHA-512/HMAC core; digests routed back by a tag FIFO.
// Latency: first beat reaches the core 1 cycle after the request is seen; 1 idle cycle between packets.
// Backpressure: core tready passes straight to the granted requester; grants stop while the tag FIFO is full.
// Optional SHA_ARB_STATS_EN adds per-requester packet counters and a digest-without-tag error flag.
module sha_core_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 512,
    parameter int ID_W      = 6,
    parameter int TAG_DEPTH = 8
) (
    input  logic              aclk,
    input  logic              areset,
    sha_core_arbiter_if.slave bus
`ifdef SHA_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0] stat_pkts,
    output logic                stat_mismatch_q
`endif
);
    localparam int GW = $clog2(N_REQ);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int KW = DATA_W / 8;

    typedef enum logic {IDLE, PASS} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [KW-1:0]     keep;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q;
    logic [GW-1:0] hit_idx;
    logic          hit;

    beat_t         sel_beat;
    logic          sel_vld;

    logic [GW-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0] tag_wr_ptr_q, tag_rd_ptr_q;
    logic [AW:0]   tag_cnt_q;
    logic          tag_full, tag_empty;
    logic          tag_push_vld, tag_pop_vld;
    logic [GW-1:0] tag_head;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[GW-1:0];
    endfunction

    // Round-robin search: lowest offset from rr_ptr wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && bus.s_req_tvalid[wrap_idx(rr_ptr_q, k)]) begin
                hit     = 1'b1;
                hit_idx = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        sel_vld       = bus.s_req_tvalid[grant_q];
        sel_beat.dat  = bus.s_req_tdata[int'(grant_q)*DATA_W +: DATA_W];
        sel_beat.keep = bus.s_req_tkeep[int'(grant_q)*KW +: KW];
        sel_beat.id   = bus.s_req_tid[int'(grant_q)*ID_W +: ID_W];
        sel_beat.last = bus.s_req_tlast[grant_q];
    end

    assign tag_push_vld = (state_q == PASS) && sel_vld && bus.m_core_tready && sel_beat.last;
    assign tag_pop_vld  = bus.s_core_tvalid && bus.s_core_tready;
    assign tag_full     = (tag_cnt_q == (AW+1)'(TAG_DEPTH));
    assign tag_empty    = (tag_cnt_q == '0);
    assign tag_head     = tag_mem[tag_rd_ptr_q];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (tag_push_vld) rr_ptr_q <= wrap_idx(grant_q, 1);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (!tag_full && hit) begin
                    state_d = PASS;
                    grant_d = hit_idx;
                end
            end
            PASS: begin
                if (tag_push_vld) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced idle while reset is held so nothing escapes mid-reset.
    always_comb begin
        bus.m_core_tvalid = 1'b0;
        bus.m_core_tdata  = sel_beat.dat;
        bus.m_core_tkeep  = sel_beat.keep;
        bus.m_core_tid    = sel_beat.id;
        bus.m_core_tlast  = sel_beat.last;
        bus.s_req_tready  = '0;
        if (state_q == PASS && !areset) begin
            bus.m_core_tvalid         = sel_vld;
            bus.s_req_tready[grant_q] = bus.m_core_tready;
        end
    end

    always_comb begin
        bus.s_core_tready = 1'b0;
        bus.m_res_tvalid  = '0;
        bus.m_res_tdata   = bus.s_core_tdata;
        if (!tag_empty && !areset) begin
            bus.m_res_tvalid[tag_head] = bus.s_core_tvalid;
            bus.s_core_tready          = bus.m_res_tready[tag_head];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
        end else begin
            if (tag_push_vld) tag_wr_ptr_q <= tag_wr_ptr_q + 1'b1;
            if (tag_pop_vld)  tag_rd_ptr_q <= tag_rd_ptr_q + 1'b1;
            case ({tag_push_vld, tag_pop_vld})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (tag_push_vld) tag_mem[tag_wr_ptr_q] <= grant_q;
    end

`ifdef SHA_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [N_REQ];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REQ; i++) pkt_cnt_q[i] <= '0;
            stat_mismatch_q <= 1'b0;
        end else begin
            if (tag_push_vld) pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
            if (bus.s_core_tvalid && tag_empty) stat_mismatch_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_pkts[g*32 +: 32] = pkt_cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter: grant order, tag routing, FIFO-full stall, reset abort.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later, well before the next edge.
// Expected values are hand-derived constants in each step.
module tb_sha_core_arbiter;
    localparam int NR = 4;
    localparam int DW = 512;
    localparam int IW = 6;

    logic aclk = 1'b0;
    logic areset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 aclk = ~aclk;

    sha_core_arbiter_if #(.N_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

`ifdef SHA_ARB_STATS_EN
    logic [NR*32-1:0] stat_pkts;
    logic             stat_mismatch_q;
`endif

    sha_core_arbiter #(.N_REQ(NR), .DATA_W(DW), .ID_W(IW), .TAG_DEPTH(8)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
`ifdef SHA_ARB_STATS_EN
        ,
        .stat_pkts       (stat_pkts),
        .stat_mismatch_q (stat_mismatch_q)
`endif
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [63:0] d,
                           input logic [IW-1:0] id, input logic last);
        bus.s_req_tvalid[r]          = v;
        bus.s_req_tdata[r*DW +: DW]  = {{(DW-64){1'b0}}, d};
        bus.s_req_tid[r*IW +: IW]    = id;
        bus.s_req_tlast[r]           = last;
    endtask

    initial begin
        bus.s_req_tvalid  = '0;
        bus.s_req_tdata   = '0;
        bus.s_req_tkeep   = '1;
        bus.s_req_tid     = '0;
        bus.s_req_tlast   = '0;
        bus.m_core_tready = 1'b1;
        bus.s_core_tvalid = 1'b0;
        bus.s_core_tdata  = '0;
        bus.m_res_tready  = '1;
        areset = 1'b1;
        step();
        step();
        settle();
        chk("rst_s_req_tready", bus.s_req_tready, 0);
        chk("rst_m_core_tvalid", bus.m_core_tvalid, 0);
        chk("rst_s_core_tready", bus.s_core_tready, 0);
        chk("rst_m_res_tvalid", bus.m_res_tvalid, 0);

        // Test 1: requester 2, three beats, tid 5, then digest 0xAB
        step();
        areset = 1'b0;
        set_req(2, 1'b1, 64'h11, 6'd5, 1'b0);
        settle();
        chk("t1_idle_vld", bus.m_core_tvalid, 0);
        chk("t1_idle_rdy", bus.s_req_tready, 0);
        step(); settle();
        chk("t1_b1_vld", bus.m_core_tvalid, 1);
        chk("t1_b1_dat", bus.m_core_tdata[63:0], 64'h11);
        chk("t1_b1_tid", bus.m_core_tid, 5);
        chk("t1_b1_rdy", bus.s_req_tready, 4'b0100);
        chk("t1_b1_last", bus.m_core_tlast, 0);
        step();
        set_req(2, 1'b1, 64'h22, 6'd5, 1'b0);
        settle();
        chk("t1_b2_dat", bus.m_core_tdata[63:0], 64'h22);
        step();
        set_req(2, 1'b1, 64'h33, 6'd5, 1'b1);
        settle();
        chk("t1_b3_dat", bus.m_core_tdata[63:0], 64'h33);
        chk("t1_b3_last", bus.m_core_tlast, 1);
        step();
        set_req(2, 1'b0, 64'h0, 6'd0, 1'b0);
        settle();
        chk("t1_after_vld", bus.m_core_tvalid, 0);
        chk("t1_tag_rdy", bus.s_core_tready, 1);
        chk("t1_res_idle", bus.m_res_tvalid, 0);
        bus.s_core_tvalid = 1'b1;
        bus.s_core_tdata  = {{(DW-8){1'b0}}, 8'hAB};
        settle();
        chk("t1_res_vld", bus.m_res_tvalid, 4'b0100);
        chk("t1_res_dat", bus.m_res_tdata[63:0], 64'hAB);
        step();
        bus.s_core_tvalid = 1'b0;
        settle();
        chk("t1_fifo_empty", bus.s_core_tready, 0);

        // Tests 2+3: all requesters valid, 1-beat packets, no digests returned
        areset = 1'b1;
        step();
        areset = 1'b0;
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 64'hA0 + 64'(r), IW'(r), 1'b1);
        settle();
        for (int p = 0; p < 8; p++) begin
            chk("t2_bubble", bus.m_core_tvalid, 0);
            step(); settle();
            chk("t2_grant", bus.s_req_tready, 64'(1 << (p % 4)));
            chk("t2_dat", bus.m_core_tdata[63:0], 64'hA0 + 64'(p % 4));
            chk("t2_tid", bus.m_core_tid, 64'(p % 4));
            step(); settle();
        end
        for (int c = 0; c < 3; c++) begin
            chk("t3_full_rdy", bus.s_req_tready, 0);
            chk("t3_full_vld", bus.m_core_tvalid, 0);
            step(); settle();
        end
        bus.s_core_tvalid = 1'b1;
        bus.s_core_tdata  = {{(DW-8){1'b0}}, 8'hD0};
        settle();
        chk("t3_res_vld", bus.m_res_tvalid, 4'b0001);
        chk("t3_core_rdy", bus.s_core_tready, 1);
        step();
        bus.s_core_tvalid = 1'b0;
        settle();
        chk("t3_idle", bus.m_core_tvalid, 0);
        step(); settle();
        chk("t3_regrant", bus.s_req_tready, 4'b0001);
        chk("t3_regrant_dat", bus.m_core_tdata[63:0], 64'hA0);
        step(); settle();
        for (int c = 0; c < 3; c++) begin
            chk("t3_refull_rdy", bus.s_req_tready, 0);
            step(); settle();
        end

        // Test 4: head tag is requester 1, which stalls for 5 cycles
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 64'h0, 6'd0, 1'b0);
        bus.m_res_tready  = 4'b1101;
        bus.s_core_tvalid = 1'b1;
        bus.s_core_tdata  = {{(DW-16){1'b0}}, 16'hBEEF};
        settle();
        for (int c = 0; c < 5; c++) begin
            chk("t4_core_rdy", bus.s_core_tready, 0);
            chk("t4_res_vld", bus.m_res_tvalid, 4'b0010);
            chk("t4_res_dat", bus.m_res_tdata[63:0], 64'hBEEF);
            step(); settle();
        end
        bus.m_res_tready = '1;
        settle();
        chk("t4_core_rdy_up", bus.s_core_tready, 1);
        step();
        bus.s_core_tdata = {{(DW-8){1'b0}}, 8'hC2};
        settle();
        chk("t4_next_head", bus.m_res_tvalid, 4'b0100);
        bus.s_core_tvalid = 1'b0;

        // Test 5: reset during beat 2 of a 4-beat packet
        areset = 1'b1;
        step();
        areset = 1'b0;
        set_req(1, 1'b1, 64'h51, 6'd1, 1'b1);
        settle();
        step(); settle();
        chk("t5_pre_grant", bus.s_req_tready, 4'b0010);
        step();
        set_req(1, 1'b0, 64'h0, 6'd0, 1'b0);
        set_req(3, 1'b1, 64'h31, 6'd3, 1'b0);
        settle();
        step(); settle();
        chk("t5_grant3", bus.s_req_tready, 4'b1000);
        chk("t5_b1_dat", bus.m_core_tdata[63:0], 64'h31);
        step();
        set_req(3, 1'b1, 64'h32, 6'd3, 1'b0);
        areset = 1'b1;
        settle();
        chk("t5_rst_rdy", bus.s_req_tready, 0);
        step();
        areset = 1'b0;
        set_req(3, 1'b0, 64'h0, 6'd0, 1'b0);
        settle();
        chk("t5_post_rdy", bus.s_req_tready, 0);
        chk("t5_post_vld", bus.m_core_tvalid, 0);
        chk("t5_post_empty", bus.s_core_tready, 0);
        set_req(1, 1'b1, 64'h61, 6'd1, 1'b1);
        set_req(3, 1'b1, 64'h63, 6'd3, 1'b1);
        settle();
        chk("t5_idle", bus.m_core_tvalid, 0);
        step(); settle();
        chk("t5_rr_reset", bus.s_req_tready, 4'b0010);
        step();
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 64'h0, 6'd0, 1'b0);

`ifdef SHA_ARB_STATS_EN
        // Test 6: packet counters and digest-without-tag flag
        areset = 1'b1;
        step();
        areset = 1'b0;
        settle();
        chk("t6_mm_rst", stat_mismatch_q, 0);
        chk("t6_cnt_rst", stat_pkts[32 +: 32], 0);
        bus.s_core_tvalid = 1'b1;
        step();
        bus.s_core_tvalid = 1'b0;
        settle();
        chk("t6_mm_set", stat_mismatch_q, 1);
        set_req(1, 1'b1, 64'h71, 6'd1, 1'b1);
        for (int c = 0; c < 6; c++) step();
        set_req(1, 1'b0, 64'h0, 6'd0, 1'b0);
        set_req(3, 1'b1, 64'h73, 6'd3, 1'b1);
        step();
        step();
        set_req(3, 1'b0, 64'h0, 6'd0, 1'b0);
        settle();
        chk("t6_cnt1", stat_pkts[32 +: 32], 3);
        chk("t6_cnt3", stat_pkts[96 +: 32], 1);
        chk("t6_cnt0", stat_pkts[0 +: 32], 0);
        chk("t6_mm_sticky", stat_mismatch_q, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
